// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Inter-stage pipeline register for the 5-stage MIPS core (F/D, D/E, E/M,
//   M/W). It carries the payload, PC, delay-slot flag, exception code and
//   valid bit. It inserts a bubble on stall, flushes to the handler entry on
//   an exception request, merges a locally detected exception, and keeps a
//   saturating count of stall bubbles.
//
// Ports
//   Clk, Rst        rising-edge clock, synchronous active-high reset
//   We              load enable (0 = hold)
//   Stall           insert a bubble this cycle
//   Req             exception taken: flush the stage to EXC_ENTRY
//   CntClr          synchronous clear of the bubble counter
//   DATA_in/PC_in/BD_in/ExcCode_in   incoming instruction state
//   ExcLocal_in/ExcLocalCode_in      exception raised by the upstream stage
//   DATA_out/PC_out/BD_out/ExcCode_out/Valid_out  registered stage state
//   BubbleCnt_out   saturating count of bubbles caused by Stall
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned DATA_W    = 128,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [4:0]  EXC_NONE  = 5'd31,
  parameter bit          CHECK_PC  = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              We,
  input  logic              Stall,
  input  logic              Req,
  input  logic              CntClr,
  input  logic [DATA_W-1:0] DATA_in,
  input  logic [31:0]       PC_in,
  input  logic              BD_in,
  input  logic [4:0]        ExcCode_in,
  input  logic              ExcLocal_in,
  input  logic [4:0]        ExcLocalCode_in,
  output logic [DATA_W-1:0] DATA_out,
  output logic [31:0]       PC_out,
  output logic              BD_out,
  output logic [4:0]        ExcCode_out,
  output logic              Valid_out,
  output logic [CNT_W-1:0]  BubbleCnt_out
);

  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [DATA_W-1:0] data_q, data_d;
  logic [31:0]       pc_q, pc_d;
  logic              bd_q, bd_d;
  logic [4:0]        exc_q, exc_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        merged_exc_c;

  // Exception merge: oldest carried exception first, then PC alignment, then local.
  always_comb begin
    merged_exc_c = EXC_NONE;
    if (ExcCode_in != EXC_NONE) begin
      merged_exc_c = ExcCode_in;
    end else if (CHECK_PC && (PC_in[1:0] != 2'b00)) begin
      merged_exc_c = EXC_ADEL;
    end else if (ExcLocal_in) begin
      merged_exc_c = ExcLocalCode_in;
    end
  end

  // Next stage state: Req > Stall > We > hold.
  always_comb begin
    data_d  = data_q;
    pc_d    = pc_q;
    bd_d    = bd_q;
    exc_d   = exc_q;
    valid_d = valid_q;
    if (Req) begin
      data_d  = '0;
      pc_d    = EXC_ENTRY;
      bd_d    = 1'b0;
      exc_d   = EXC_NONE;
      valid_d = 1'b0;
    end else if (Stall) begin
      // Bubble keeps PC/BD so EPC stays correct if an interrupt lands on it.
      data_d  = '0;
      pc_d    = PC_in;
      bd_d    = BD_in;
      exc_d   = EXC_NONE;
      valid_d = 1'b0;
    end else if (We) begin
      // A faulting instruction carries no payload so it cannot cause side effects.
      data_d  = (merged_exc_c != EXC_NONE) ? '0 : DATA_in;
      pc_d    = PC_in;
      bd_d    = BD_in;
      exc_d   = merged_exc_c;
      valid_d = 1'b1;
    end
  end

  // Bubble counter: clear wins over increment, saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (CntClr) begin
      cnt_d = '0;
    end else if (Stall && !Req && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      data_q  <= '0;
      pc_q    <= '0;
      bd_q    <= 1'b0;
      exc_q   <= EXC_NONE;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      pc_q    <= pc_d;
      bd_q    <= bd_d;
      exc_q   <= exc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign DATA_out      = data_q;
  assign PC_out        = pc_q;
  assign BD_out        = bd_q;
  assign ExcCode_out   = exc_q;
  assign Valid_out     = valid_q;
  assign BubbleCnt_out = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: two instances (defaults, and CHECK_PC=1 with
// a 2-bit counter) driven by the same stimulus, compared each edge against a
// behavioural model of the stage.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 128;
  localparam logic [31:0] ENTRY = 32'h0000_4180;
  localparam logic [4:0]  NONE  = 5'd31;

  logic          Clk = 1'b0;
  logic          Rst, We, Stall, Req, CntClr, BD_in, ExcLocal_in;
  logic [DW-1:0] DATA_in;
  logic [31:0]   PC_in;
  logic [4:0]    ExcCode_in, ExcLocalCode_in;

  logic [DW-1:0] d0_data, d1_data;
  logic [31:0]   d0_pc, d1_pc;
  logic          d0_bd, d1_bd, d0_valid, d1_valid;
  logic [4:0]    d0_exc, d1_exc;
  logic [15:0]   d0_cnt;
  logic [1:0]    d1_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  pipe_stage_reg #(.DATA_W(DW), .EXC_ENTRY(ENTRY), .EXC_NONE(NONE),
                   .CHECK_PC(1'b0), .CNT_W(16)) dut0 (
    .Clk(Clk), .Rst(Rst), .We(We), .Stall(Stall), .Req(Req), .CntClr(CntClr),
    .DATA_in(DATA_in), .PC_in(PC_in), .BD_in(BD_in), .ExcCode_in(ExcCode_in),
    .ExcLocal_in(ExcLocal_in), .ExcLocalCode_in(ExcLocalCode_in),
    .DATA_out(d0_data), .PC_out(d0_pc), .BD_out(d0_bd), .ExcCode_out(d0_exc),
    .Valid_out(d0_valid), .BubbleCnt_out(d0_cnt));

  pipe_stage_reg #(.DATA_W(DW), .EXC_ENTRY(ENTRY), .EXC_NONE(NONE),
                   .CHECK_PC(1'b1), .CNT_W(2)) dut1 (
    .Clk(Clk), .Rst(Rst), .We(We), .Stall(Stall), .Req(Req), .CntClr(CntClr),
    .DATA_in(DATA_in), .PC_in(PC_in), .BD_in(BD_in), .ExcCode_in(ExcCode_in),
    .ExcLocal_in(ExcLocal_in), .ExcLocalCode_in(ExcLocalCode_in),
    .DATA_out(d1_data), .PC_out(d1_pc), .BD_out(d1_bd), .ExcCode_out(d1_exc),
    .Valid_out(d1_valid), .BubbleCnt_out(d1_cnt));

  typedef struct {
    logic [DW-1:0] data;
    logic [31:0]   pc;
    logic          bd;
    logic [4:0]    exc;
    logic          valid;
    int            cnt;
  } model_t;

  model_t m0, m1;

  // Reference behaviour of one edge, straight from the stage rules.
  function automatic model_t model_edge(model_t s, bit chk_pc, int cnt_max);
    model_t n = s;
    logic [4:0] code;
    if (Rst) begin
      n.data = '0; n.pc = '0; n.bd = 0; n.exc = NONE; n.valid = 0; n.cnt = 0;
      return n;
    end
    if (CntClr) n.cnt = 0;
    else if (Stall && !Req) n.cnt = (s.cnt + 1 > cnt_max) ? cnt_max : s.cnt + 1;
    if (Req) begin
      n.data = '0; n.pc = ENTRY; n.bd = 0; n.exc = NONE; n.valid = 0;
    end else if (Stall) begin
      n.data = '0; n.pc = PC_in; n.bd = BD_in; n.exc = NONE; n.valid = 0;
    end else if (We) begin
      if (ExcCode_in != NONE)                code = ExcCode_in;
      else if (chk_pc && (PC_in % 4 != 0))   code = 5'd4;
      else if (ExcLocal_in)                  code = ExcLocalCode_in;
      else                                   code = NONE;
      n.exc = code;
      n.data = (code == NONE) ? DATA_in : '0;
      n.pc = PC_in; n.bd = BD_in; n.valid = 1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("d0.data",  d0_data,        m0.data);
    chk("d0.pc",    DW'(d0_pc),     DW'(m0.pc));
    chk("d0.bd",    DW'(d0_bd),     DW'(m0.bd));
    chk("d0.exc",   DW'(d0_exc),    DW'(m0.exc));
    chk("d0.valid", DW'(d0_valid),  DW'(m0.valid));
    chk("d0.cnt",   DW'(d0_cnt),    DW'(m0.cnt));
    chk("d1.data",  d1_data,        m1.data);
    chk("d1.pc",    DW'(d1_pc),     DW'(m1.pc));
    chk("d1.bd",    DW'(d1_bd),     DW'(m1.bd));
    chk("d1.exc",   DW'(d1_exc),    DW'(m1.exc));
    chk("d1.valid", DW'(d1_valid),  DW'(m1.valid));
    chk("d1.cnt",   DW'(d1_cnt),    DW'(m1.cnt));
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge Clk);
    m0 = model_edge(m0, 1'b0, 65535);
    m1 = model_edge(m1, 1'b1, 3);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    Rst = 0; We = 0; Stall = 0; Req = 0; CntClr = 0; BD_in = 0;
    ExcLocal_in = 0; ExcLocalCode_in = 5'd0; ExcCode_in = NONE;
  endtask

  initial begin
    m0 = '{data: '0, pc: '0, bd: 0, exc: NONE, valid: 0, cnt: 0};
    m1 = m0;
    idle_inputs();
    DATA_in = '0; PC_in = '0;
    Rst = 1;
    step();
    chk("reset.pc",    DW'(d0_pc),    DW'(32'h0));
    chk("reset.exc",   DW'(d0_exc),   DW'(NONE));
    chk("reset.valid", DW'(d0_valid), DW'(1'b0));
    chk("reset.cnt",   DW'(d0_cnt),   DW'(16'd0));

    // Plain load
    idle_inputs();
    We = 1; PC_in = 32'h3000; BD_in = 1; DATA_in = {16{8'hA5}};
    step();
    chk("load.valid", DW'(d0_valid), DW'(1'b1));
    chk("load.data",  d0_data,       {16{8'hA5}});

    // Three stall bubbles
    Stall = 1; PC_in = 32'h3004; BD_in = 0;
    repeat (3) step();
    chk("stall.cnt3", DW'(d0_cnt), DW'(16'd3));
    chk("stall.pc",   DW'(d0_pc),  DW'(32'h3004));
    // Two more: 2-bit counter saturates
    repeat (2) step();
    chk("stall.sat", DW'(d1_cnt), DW'(2'd3));
    chk("stall.cnt5", DW'(d0_cnt), DW'(16'd5));

    // Req beats Stall and We, counter unchanged
    Req = 1; Stall = 1; We = 1;
    step();
    chk("req.pc",  DW'(d0_pc),  DW'(ENTRY));
    chk("req.cnt", DW'(d0_cnt), DW'(16'd5));

    // Exception merge cases
    idle_inputs(); We = 1; PC_in = 32'h3008; DATA_in = {4{32'hDEADBEEF}};
    ExcCode_in = 5'd12; ExcLocal_in = 1; ExcLocalCode_in = 5'd10;
    step();
    chk("merge.old",  DW'(d0_exc), DW'(5'd12));
    chk("merge.data", d0_data,     '0);
    ExcCode_in = NONE;
    step();
    chk("merge.local", DW'(d0_exc), DW'(5'd10));
    ExcLocal_in = 0; PC_in = 32'h3002;
    step();
    chk("merge.adel", DW'(d1_exc), DW'(5'd4));
    chk("merge.nochk", DW'(d0_exc), DW'(NONE));

    // Hold with changing inputs
    We = 0;
    PC_in = 32'h5000; DATA_in = {4{32'h12345678}}; BD_in = 1;
    step();
    PC_in = 32'h6000; ExcLocal_in = 1; ExcLocalCode_in = 5'd7;
    step();
    chk("hold.pc", DW'(d0_pc), DW'(32'h3002));

    // Clear beats increment
    idle_inputs(); Stall = 1; CntClr = 1;
    step();
    chk("clr.cnt", DW'(d0_cnt), DW'(16'd0));

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      Rst         = ($urandom_range(0, 49) == 0);
      Req         = ($urandom_range(0, 9) == 0);
      Stall       = ($urandom_range(0, 3) == 0);
      We          = ($urandom_range(0, 9) < 7);
      CntClr      = ($urandom_range(0, 19) == 0);
      DATA_in     = {$urandom, $urandom, $urandom, $urandom};
      PC_in       = $urandom;
      BD_in       = 1'($urandom);
      ExcCode_in  = ($urandom_range(0, 1) == 0) ? NONE : 5'($urandom_range(0, 30));
      ExcLocal_in = 1'($urandom);
      ExcLocalCode_in = 5'($urandom_range(0, 30));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
